if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and issues requests to instruction memory, which may insert wait states. It selects the next PC from the sequential, branch, jump, exception and interrupt sources. It presents PCIF, PCplus4IF and instructionIF, plus valid and flush qualifiers, to the IF/ID pipeline register directly downstream.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_pc_sel.sv | 40 ++++
 rtl/if_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch reset/trap vectors, fetch FSM states,
// redirect sources and the supervisor-preserving PC increment.
`timescale 1ns/1ps
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INTR_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_e;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_INTR,
    SRC_EXC,
    SRC_BRANCH,
    SRC_JUMP
  } redirect_src_e;

  // Bit 31 is the supervisor bit; the offset wraps within the low 31 bits.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Redirect priority mux for the fetch stage: interrupt (user mode only) >
// exception > branch > jump.
`timescale 1ns/1ps
module if_pc_sel
  import mips_pkg::*;
(
  input  logic          intterupt,
  input  logic          exception,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  input  logic          pc_if_msb,
  output logic          redirect,
  output logic [31:0]   target,
  output redirect_src_e src
);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    src    = SRC_NONE;
    target = '0;
    if (intterupt && !pc_if_msb) begin
      src    = SRC_INTR;
      target = INTR_VEC;
    end else if (exception) begin
      src    = SRC_EXC;
      target = EXC_VEC;
    end else if (branch_taken) begin
      src    = SRC_BRANCH;
      target = branch_target;
    end else if (jump) begin
      src    = SRC_JUMP;
      target = jump_target;
    end
  end

  assign redirect = (src != SRC_NONE);

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, wait-state tolerant imem fetch,
// stall hold and redirect drain. IF_BRANCH_DELAY_SLOT_EN keeps delay slots.
`timescale 1ns/1ps
module if_fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        intterupt,
  input  logic        exception,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCIF,
  output logic [31:0] PCplus4IF,
  output logic [31:0] instructionIF,
  output logic        validIF,
  output logic        flush_ifid
);

  fetch_state_e  state;
  logic [31:0]   pc;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_instr;
  logic [31:0]   pend_pc;
  logic          redirect;
  logic [31:0]   target;
  redirect_src_e src;
  logic          kills_src;
  logic          flush_now;

  always_comb begin
    PCIF = pc;
    if (reset)              PCIF = RESET_PC;
    else if (state == HOLD) PCIF = hold_pc;
  end

  assign PCplus4IF = pc_plus4(PCIF);

  if_pc_sel u_pc_sel (
    .intterupt     (intterupt),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_if_msb     (PCIF[31]),
    .redirect      (redirect),
    .target        (target),
    .src           (src)
  );

`ifdef IF_BRANCH_DELAY_SLOT_EN
  // Branches and jumps keep the delay-slot instruction; only traps squash it.
  assign kills_src = (src == SRC_INTR) || (src == SRC_EXC);
`else
  assign kills_src = (src != SRC_NONE);
`endif

  assign flush_now  = !reset && redirect && kills_src;
  assign flush_ifid = flush_now;

  always_comb begin
    imem_req      = 1'b0;
    imem_addr     = pc;
    instructionIF = '0;
    validIF       = 1'b0;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            instructionIF = imem_rdata;
            validIF       = !flush_now;
          end
        end
        HOLD: begin
          instructionIF = hold_instr;
          validIF       = !flush_now;
        end
        DRAIN:   imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      // NOTE: hold/pend data is reset too, so a reset mid-wait leaks nothing.
      hold_pc    <= '0;
      hold_instr <= '0;
      pend_pc    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              pc <= target;
            end else if (stall) begin
              hold_pc    <= pc;
              hold_instr <= imem_rdata;
              state      <= HOLD;
            end else begin
              pc <= pc_plus4(pc);
            end
          end else if (redirect) begin
            pend_pc <= target;
            state   <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus4(pc);
            state <= FETCH;
          end
        end
        DRAIN: begin
          // The late response belongs to the abandoned address and is dropped.
          if (imem_ready) begin
            pc    <= redirect ? target : pend_pc;
            state <= FETCH;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed cycle table plus randomized
// traffic against a behavioural fetch model.
`timescale 1ns/1ps
module tb_if_fetch_stage;

`ifdef IF_BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] I_VEC  = 32'h8000_0004;
  localparam logic [31:0] E_VEC  = 32'h8000_0008;

  logic        clk;
  logic        reset, intterupt, exception, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_ready;
  logic        imem_req, validIF, flush_ifid;
  logic [31:0] imem_addr, PCIF, PCplus4IF, instructionIF;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .intterupt     (intterupt),
    .exception     (exception),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .PCIF          (PCIF),
    .PCplus4IF     (PCplus4IF),
    .instructionIF (instructionIF),
    .validIF       (validIF),
    .flush_ifid    (flush_ifid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Supervisor bit fixed, low 31 bits advance modulo 2^31.
  function automatic logic [31:0] seq(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  // Behavioural model: where the PC is, whether an instruction is parked,
  // whether an abandoned fetch is still outstanding.
  logic [31:0] m_pc = RST_PC, m_hold_pc = '0, m_hold_instr = '0, m_pend = '0;
  bit          m_held = 0, m_drain = 0;

  task automatic run_cycle();
    logic [31:0] pcif, tgt, instr;
    bit intr_ok, redir, kills, present;
    pcif    = reset ? RST_PC : (m_held ? m_hold_pc : m_pc);
    intr_ok = intterupt && !pcif[31];
    redir   = !reset && (intr_ok || exception || branch_taken || jump);
    tgt     = intr_ok ? I_VEC : exception ? E_VEC : branch_taken ? branch_target : jump_target;
    kills   = redir && (DS ? (intr_ok || exception) : 1'b1);
    present = !reset && (m_held || (!m_drain && imem_ready));
    instr   = !present ? 32'h0 : (m_held ? m_hold_instr : imem_rdata);
    check("m_pcif", PCIF, pcif);
    check("m_pc4", PCplus4IF, seq(pcif));
    check("m_req", imem_req, !reset && !m_held);
    if (imem_req === 1'b1) check("m_addr", imem_addr, m_pc);
    check("m_valid", validIF, present && !kills);
    check("m_flush", flush_ifid, kills);
    check("m_instr", instructionIF, instr);
    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC; m_held = 0; m_drain = 0;
      m_hold_pc = '0; m_hold_instr = '0; m_pend = '0;
    end else if (m_held) begin
      if (redir) begin m_pc = tgt; m_held = 0; end
      else if (!stall) begin m_pc = seq(m_pc); m_held = 0; end
    end else if (m_drain) begin
      if (imem_ready) begin m_pc = redir ? tgt : m_pend; m_drain = 0; end
      else if (redir) m_pend = tgt;
    end else if (imem_ready) begin
      if (redir) m_pc = tgt;
      else if (stall) begin m_held = 1; m_hold_pc = m_pc; m_hold_instr = imem_rdata; end
      else m_pc = seq(m_pc);
    end else if (redir) begin
      m_pend = tgt; m_drain = 1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic rst, rdy, stl, intr, exc, br, jmp;
    logic [31:0] tgt;
    logic [31:0] pcif;
    logic valid, req, flush;
    logic [31:0] instr;
  } vec_t;

  function automatic vec_t mk(input logic rst, rdy, stl, intr, exc, br, jmp,
                              input logic [31:0] tgt, pcif,
                              input logic valid, req, flush,
                              input logic [31:0] instr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.stl = stl; v.intr = intr; v.exc = exc;
    v.br = br; v.jmp = jmp; v.tgt = tgt; v.pcif = pcif;
    v.valid = valid; v.req = req; v.flush = flush; v.instr = instr;
    return v;
  endfunction

  vec_t tbl[27];

  initial begin
    //             rst rdy stl int exc br jmp tgt           pcif          v   req flush instr
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         RST_PC,        0,  0, 0,   32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         RST_PC,        0,  0, 0,   32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0000, 1,  1, 0,   32'h8000_0000);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0004, 0,  1, 0,   32'h0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0004, 0,  1, 0,   32'h0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0004, 1,  1, 0,   32'h8000_0004);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0008, 1,  1, 0,   32'h8000_0008);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,         32'h8000_000C, 1,  1, 0,   32'h8000_000C);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h8000_000C, 1,  0, 0,   32'h8000_000C);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h8000_000C, 1,  0, 0,   32'h8000_000C);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h8000_000C, 1,  0, 0,   32'h8000_000C);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0010, 1,  1, 0,   32'h8000_0010);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0040_0020, 32'h8000_0014, 0,  1, !DS, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0014, 0,  1, 0,   32'h0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0014, 0,  1, 0,   32'h0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0040_0020, 1,  1, 0,   32'h0040_0020);
    tbl[16] = mk(0, 1, 0, 1, 0, 0, 0, 32'h0,         32'h0040_0024, 0,  1, 1,   32'h0040_0024);
    tbl[17] = mk(0, 1, 0, 1, 0, 0, 0, 32'h0,         32'h8000_0004, 1,  1, 0,   32'h8000_0004);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0008, 1,  1, 0,   32'h8000_0008);
    tbl[19] = mk(0, 1, 0, 0, 1, 0, 1, 32'h0040_0100, 32'h8000_000C, 0,  1, 1,   32'h8000_000C);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0008, 1,  1, 0,   32'h8000_0008);
    tbl[21] = mk(0, 1, 0, 0, 0, 1, 0, 32'h7FFF_FFFC, 32'h8000_000C, DS, 1, !DS, 32'h8000_000C);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h7FFF_FFFC, 1,  1, 0,   32'h7FFF_FFFC);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 1,  1, 0,   32'h0000_0000);
    tbl[24] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0040_0040, 32'h0000_0004, 0,  1, !DS, 32'h0);
    tbl[25] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,         RST_PC,        0,  0, 0,   32'h0);
    tbl[26] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h8000_0000, 1,  1, 0,   32'h8000_0000);

    reset = 1; intterupt = 0; exception = 0; stall = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0; imem_rdata = '0; imem_ready = 0;
    @(negedge clk);

    // Directed cycle table; memory returns its own address as data.
    for (int i = 0; i < 27; i++) begin
      reset = tbl[i].rst; imem_ready = tbl[i].rdy; stall = tbl[i].stl;
      intterupt = tbl[i].intr; exception = tbl[i].exc;
      branch_taken = tbl[i].br; jump = tbl[i].jmp;
      branch_target = tbl[i].tgt; jump_target = tbl[i].tgt;
      imem_rdata = m_pc;
      #1;
      check($sformatf("t%0d_pcif", i), PCIF, tbl[i].pcif);
      check($sformatf("t%0d_valid", i), validIF, tbl[i].valid);
      check($sformatf("t%0d_req", i), imem_req, tbl[i].req);
      check($sformatf("t%0d_flush", i), flush_ifid, tbl[i].flush);
      check($sformatf("t%0d_instr", i), instructionIF, tbl[i].instr);
      if (i == 22) check("t22_pc4_wrap", PCplus4IF, 32'h0000_0000);
      run_cycle();
    end

    // Randomized traffic against the model, with occasional resets.
    reset = 1; intterupt = 0; exception = 0; stall = 0; branch_taken = 0; jump = 0;
    #1; run_cycle();
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(99) < 1);
      imem_ready    = ($urandom_range(99) < 60);
      stall         = ($urandom_range(99) < 20);
      intterupt     = ($urandom_range(99) < 5);
      exception     = ($urandom_range(99) < 3);
      branch_taken  = ($urandom_range(99) < 6);
      jump          = ($urandom_range(99) < 5);
      branch_target = {$urandom_range(1), 29'($urandom), 2'b00};
      jump_target   = {$urandom_range(1), 29'($urandom), 2'b00};
      imem_rdata    = $urandom;
      #1;
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
